// File: rtl/axis_bandwidth_monitor.sv
// Passive AXI-Stream handshake utilisation monitor: per-channel valid/ready/transfer counts per
// window, moving-average outputs over the last 2^AVG_LOG2 windows, and a clearable transfer peak.
module axis_bandwidth_monitor #(
    parameter int NUM_CH       = 2,
    parameter int WINDOW_WIDTH = 16,
    parameter int AVG_LOG2     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  s_axis_tvalid,
    input  logic [NUM_CH-1:0]                  m_axis_tready,
    input  logic                               peak_clr,
    output logic [NUM_CH*(WINDOW_WIDTH+1)-1:0] n_valid_avg,
    output logic [NUM_CH*(WINDOW_WIDTH+1)-1:0] n_ready_avg,
    output logic [NUM_CH*(WINDOW_WIDTH+1)-1:0] n_both_avg,
    output logic [NUM_CH*(WINDOW_WIDTH+1)-1:0] n_both_peak,
    output logic                               update,
    output logic [15:0]                        window_cnt
);
    localparam int CW    = WINDOW_WIDTH + 1;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = CW + AVG_LOG2;
    localparam int NT    = 3;

    logic [WINDOW_WIDTH-1:0] wc_q, wc_d;
    logic                    win_last;
    logic                    close_q, close_d;
    logic                    update_q, update_d;
    logic [15:0]             window_cnt_q, window_cnt_d;

    // close_q marks the cycle after a window closed, when sums and peaks absorb it
    assign win_last = (wc_q == {WINDOW_WIDTH{1'b1}});

    always_comb begin
        wc_d         = wc_q + 1'b1;
        close_d      = win_last;
        update_d     = close_q;
        window_cnt_d = window_cnt_q + (close_q ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wc_q         <= '0;
            close_q      <= 1'b0;
            update_q     <= 1'b0;
            window_cnt_q <= '0;
        end else begin
            wc_q         <= wc_d;
            close_q      <= close_d;
            update_q     <= update_d;
            window_cnt_q <= window_cnt_d;
        end
    end

    assign update     = update_q;
    assign window_cnt = window_cnt_q;

    // Event bits per channel: 0 = valid, 1 = ready, 2 = transfer
    logic [NT-1:0] ev [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ev[gi] = {s_axis_tvalid[gi] & m_axis_tready[gi],
                             m_axis_tready[gi], s_axis_tvalid[gi]};

            for (genvar gt = 0; gt < NT; gt++) begin : g_type
                logic [CW-1:0] live_q, live_d;
                logic [CW-1:0] closed;
                logic [CW-1:0] hist_q [DEPTH];
                logic [CW-1:0] newest_q, oldest_q;
                logic [SW-1:0] sum_q, sum_d;

                // The closing cycle's own event is folded in so no boundary cycle is lost
                assign closed = live_q + CW'(ev[gi][gt]);

                always_comb begin
                    live_d = win_last ? '0 : closed;
                    sum_d  = close_q ? (sum_q + SW'(newest_q) - SW'(oldest_q)) : sum_q;
                end

                always_ff @(posedge clk) begin
                    if (!rst) begin
                        live_q   <= '0;
                        newest_q <= '0;
                        oldest_q <= '0;
                        sum_q    <= '0;
                        for (int k = 0; k < DEPTH; k++) begin
                            hist_q[k] <= '0;
                        end
                    end else begin
                        live_q <= live_d;
                        sum_q  <= sum_d;
                        if (win_last) begin
                            newest_q  <= closed;
                            oldest_q  <= hist_q[DEPTH-1];
                            hist_q[0] <= closed;
                            for (int k = 1; k < DEPTH; k++) begin
                                hist_q[k] <= hist_q[k-1];
                            end
                        end
                    end
                end

                if (gt == 0) begin : g_valid
                    assign n_valid_avg[gi*CW +: CW] = sum_q[SW-1:AVG_LOG2];
                end else if (gt == 1) begin : g_ready
                    assign n_ready_avg[gi*CW +: CW] = sum_q[SW-1:AVG_LOG2];
                end else begin : g_xfer
                    logic [CW-1:0] peak_q, peak_d;

                    // A clear landing on the refresh edge restarts the peak at the new window
                    always_comb begin
                        peak_d = peak_q;
                        if (close_q && peak_clr) begin
                            peak_d = newest_q;
                        end else if (peak_clr) begin
                            peak_d = '0;
                        end else if (close_q && (newest_q > peak_q)) begin
                            peak_d = newest_q;
                        end
                    end

                    always_ff @(posedge clk) begin
                        if (!rst) begin
                            peak_q <= '0;
                        end else begin
                            peak_q <= peak_d;
                        end
                    end

                    assign n_both_avg[gi*CW +: CW]  = sum_q[SW-1:AVG_LOG2];
                    assign n_both_peak[gi*CW +: CW] = peak_q;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_axis_bandwidth_monitor.sv
// Bench for axis_bandwidth_monitor: directed scenarios with constant expectations plus random
// traffic checked against a per-window count model.
module tb_axis_bandwidth_monitor;
    localparam int NUM_CH = 2;
    localparam int WW     = 4;
    localparam int AL     = 2;
    localparam int CW     = WW + 1;
    localparam int WLEN   = 1 << WW;
    localparam int DEPTH  = 1 << AL;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    s_axis_tvalid;
    logic [NUM_CH-1:0]    m_axis_tready;
    logic                 peak_clr;
    logic [NUM_CH*CW-1:0] n_valid_avg, n_ready_avg, n_both_avg, n_both_peak;
    logic                 update;
    logic [15:0]          window_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: cycle index since reset release and completed per-window counts
    int   cyc;
    int   nwin;
    int   live     [NUM_CH][3];
    int   wins     [256][NUM_CH][3];
    int   exp_peak [NUM_CH];
    int   exp_avg  [NUM_CH][3];
    logic exp_update;
    int   exp_wcnt;

    axis_bandwidth_monitor #(
        .NUM_CH      (NUM_CH),
        .WINDOW_WIDTH(WW),
        .AVG_LOG2    (AL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .peak_clr     (peak_clr),
        .n_valid_avg  (n_valid_avg),
        .n_ready_avg  (n_ready_avg),
        .n_both_avg   (n_both_avg),
        .n_both_peak  (n_both_peak),
        .update       (update),
        .window_cnt   (window_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] dut_avg(input int ch, input int t);
        if (t == 0) return n_valid_avg[ch*CW +: CW];
        if (t == 1) return n_ready_avg[ch*CW +: CW];
        return n_both_avg[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] dut_peak(input int ch);
        return n_both_peak[ch*CW +: CW];
    endfunction

    // Drive one cycle, advance the model past the edge, then settle for sampling
    task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                        input logic clr, input logic rn);
        int m;
        int s;
        int nb;
        s_axis_tvalid = v;
        m_axis_tready = r;
        peak_clr      = clr;
        rst           = rn;
        @(posedge clk);
        if (!rn) begin
            cyc  = 0;
            nwin = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                exp_peak[ch] = 0;
                for (int t = 0; t < 3; t++) live[ch][t] = 0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                live[ch][0] += int'(v[ch]);
                live[ch][1] += int'(r[ch]);
                live[ch][2] += int'(v[ch] & r[ch]);
            end
            if (cyc % WLEN == WLEN - 1) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    for (int t = 0; t < 3; t++) begin
                        wins[nwin % 256][ch][t] = live[ch][t];
                        live[ch][t] = 0;
                    end
                nwin++;
            end
            cyc++;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (cyc > WLEN && (cyc - 1) % WLEN == 0) begin
                    nb = wins[((cyc - 1) / WLEN - 1) % 256][ch][2];
                    if (clr) exp_peak[ch] = nb;
                    else if (nb > exp_peak[ch]) exp_peak[ch] = nb;
                end else if (clr) begin
                    exp_peak[ch] = 0;
                end
            end
        end
        exp_update = (cyc > WLEN) && ((cyc - 1) % WLEN == 0);
        m = (cyc >= 1) ? (cyc - 1) / WLEN : 0;
        exp_wcnt = m % 65536;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int t = 0; t < 3; t++) begin
                s = 0;
                for (int j = m - DEPTH; j < m; j++)
                    if (j >= 0) s += wins[j % 256][ch][t];
                exp_avg[ch][t] = s / DEPTH;
            end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            step(NUM_CH'($urandom), NUM_CH'($urandom), 1'($urandom), 1'b0);
        compared += 6;
        if (update !== 1'b0) begin mismatched++; $display("FAIL reset_update got=%b want=0", update); end
        if (window_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_wcnt got=%h want=0", window_cnt); end
        if (n_valid_avg !== '0) begin mismatched++; $display("FAIL reset_valid got=%h want=0", n_valid_avg); end
        if (n_ready_avg !== '0) begin mismatched++; $display("FAIL reset_ready got=%h want=0", n_ready_avg); end
        if (n_both_avg !== '0) begin mismatched++; $display("FAIL reset_both got=%h want=0", n_both_avg); end
        if (n_both_peak !== '0) begin mismatched++; $display("FAIL reset_peak got=%h want=0", n_both_peak); end
        $display("test_reset: outputs held at zero under reset");
    endtask

    task automatic test_full();
        int k = 0;
        int first = -1;
        int e;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7 * WLEN + 2; i++) begin
            step(2'b01, 2'b01, 1'b0, 1'b1);
            compared++;
            if (update !== exp_update) begin mismatched++; $display("FAIL full_update cyc=%0d got=%b want=%b", cyc, update, exp_update); end
            if (update === 1'b1) begin
                k++;
                if (first < 0) first = cyc;
                e = (4 * k > 16) ? 16 : 4 * k;
                $display("full: update %0d at cycle %0d both_avg=%0d peak=%0d wcnt=%0d", k, cyc, dut_avg(0, 2), dut_peak(0), window_cnt);
                compared += 9;
                for (int t = 0; t < 3; t++) begin
                    if (dut_avg(0, t) !== CW'(e)) begin mismatched++; $display("FAIL full_ch0_avg%0d got=%0d want=%0d", t, dut_avg(0, t), e); end
                    if (dut_avg(1, t) !== '0) begin mismatched++; $display("FAIL full_ch1_avg%0d got=%0d want=0", t, dut_avg(1, t)); end
                end
                if (dut_peak(0) !== CW'(16)) begin mismatched++; $display("FAIL full_peak0 got=%0d want=16", dut_peak(0)); end
                if (dut_peak(1) !== '0) begin mismatched++; $display("FAIL full_peak1 got=%0d want=0", dut_peak(1)); end
                if (window_cnt !== 16'(k)) begin mismatched++; $display("FAIL full_wcnt got=%0d want=%0d", window_cnt, k); end
            end
        end
        compared++;
        if (first != 17) begin mismatched++; $display("FAIL full_first_update got=%0d want=17", first); end
    endtask

    task automatic test_toggle();
        int k = 0;
        int w;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6 * WLEN + 2; i++) begin
            step(2'b01, {1'b0, 1'(cyc % 2 == 0)}, 1'b0, 1'b1);
            compared++;
            if (update !== exp_update) begin mismatched++; $display("FAIL toggle_update cyc=%0d got=%b want=%b", cyc, update, exp_update); end
            if (update === 1'b1) begin
                k++;
                w = (k > 4) ? 4 : k;
                $display("toggle: update %0d valid=%0d ready=%0d both=%0d peak=%0d", k, dut_avg(0, 0), dut_avg(0, 1), dut_avg(0, 2), dut_peak(0));
                compared += 4;
                if (dut_avg(0, 0) !== CW'(4 * w)) begin mismatched++; $display("FAIL toggle_valid got=%0d want=%0d", dut_avg(0, 0), 4 * w); end
                if (dut_avg(0, 1) !== CW'(2 * w)) begin mismatched++; $display("FAIL toggle_ready got=%0d want=%0d", dut_avg(0, 1), 2 * w); end
                if (dut_avg(0, 2) !== CW'(2 * w)) begin mismatched++; $display("FAIL toggle_both got=%0d want=%0d", dut_avg(0, 2), 2 * w); end
                if (dut_peak(0) !== CW'(8)) begin mismatched++; $display("FAIL toggle_peak got=%0d want=8", dut_peak(0)); end
            end
        end
    endtask

    task automatic test_single();
        logic [WLEN-1:0] mask = '0;
        logic v1;
        logic v0;
        int k = 0;
        while ($countones(mask) < 5) mask[$urandom_range(WLEN - 1, 0)] = 1'b1;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6 * WLEN + 2; i++) begin
            v1 = 1'($urandom);
            v0 = (cyc < WLEN) && mask[cyc % WLEN];
            step({v1, v0}, {~v1, 1'(cyc < WLEN)}, 1'b0, 1'b1);
            if (update === 1'b1) begin
                k++;
                $display("single: update %0d both=%0d peak=%0d", k, dut_avg(0, 2), dut_peak(0));
                compared += 3;
                if (dut_avg(0, 2) !== CW'((k <= 4) ? 1 : 0)) begin mismatched++; $display("FAIL single_both got=%0d want=%0d", dut_avg(0, 2), (k <= 4) ? 1 : 0); end
                if (dut_peak(0) !== CW'(5)) begin mismatched++; $display("FAIL single_peak got=%0d want=5", dut_peak(0)); end
                if (dut_peak(1) !== '0) begin mismatched++; $display("FAIL single_peak1 got=%0d want=0", dut_peak(1)); end
            end
        end
        compared++;
        if (k != 6) begin mismatched++; $display("FAIL single_updates got=%0d want=6", k); end
    endtask

    task automatic test_decay();
        int k = 0;
        int w;
        int e;
        logic a;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 180; i++) begin
            w = cyc / WLEN;
            a = (w < 4) || (w == 9) || (w == 10 && cyc % WLEN < 7);
            step({1'b0, a}, {1'b0, a}, 1'((cyc == 130) || (cyc == 176)), 1'b1);
            if (update === 1'b1 && k < 8) begin
                k++;
                e = (k <= 4) ? 4 * k : 4 * (8 - k);
                $display("decay: update %0d both=%0d peak=%0d", k, dut_avg(0, 2), dut_peak(0));
                compared += 2;
                if (dut_avg(0, 2) !== CW'(e)) begin mismatched++; $display("FAIL decay_both got=%0d want=%0d", dut_avg(0, 2), e); end
                if (dut_peak(0) !== CW'(16)) begin mismatched++; $display("FAIL decay_peak_hold got=%0d want=16", dut_peak(0)); end
            end
            if (cyc == 131) begin
                compared++;
                if (dut_peak(0) !== '0) begin mismatched++; $display("FAIL decay_peak_clr got=%0d want=0", dut_peak(0)); end
            end
            if (cyc == 161) begin
                compared++;
                if (dut_peak(0) !== CW'(16)) begin mismatched++; $display("FAIL decay_peak_refill got=%0d want=16", dut_peak(0)); end
            end
            if (cyc == 177) begin
                $display("decay: clear on refresh edge peak=%0d", dut_peak(0));
                compared += 2;
                if (update !== 1'b1) begin mismatched++; $display("FAIL decay_coincide_update got=%b want=1", update); end
                if (dut_peak(0) !== CW'(7)) begin mismatched++; $display("FAIL decay_coincide_peak got=%0d want=7", dut_peak(0)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 41; i++) step(NUM_CH'($urandom), NUM_CH'($urandom), 1'b0, 1'b1);
        compared++;
        if (window_cnt !== 16'd2) begin mismatched++; $display("FAIL mid_pre_wcnt got=%0d want=2", window_cnt); end
        step(NUM_CH'($urandom), NUM_CH'($urandom), 1'b0, 1'b0);
        compared += 6;
        if (update !== 1'b0) begin mismatched++; $display("FAIL mid_update got=%b want=0", update); end
        if (window_cnt !== 16'd0) begin mismatched++; $display("FAIL mid_wcnt got=%0d want=0", window_cnt); end
        if (n_valid_avg !== '0) begin mismatched++; $display("FAIL mid_valid got=%h want=0", n_valid_avg); end
        if (n_ready_avg !== '0) begin mismatched++; $display("FAIL mid_ready got=%h want=0", n_ready_avg); end
        if (n_both_avg !== '0) begin mismatched++; $display("FAIL mid_both got=%h want=0", n_both_avg); end
        if (n_both_peak !== '0) begin mismatched++; $display("FAIL mid_peak got=%h want=0", n_both_peak); end
        for (int i = 0; i < 2 * WLEN; i++) begin
            step(2'b10, 2'b10, 1'b0, 1'b1);
            if (update === 1'b1 && first < 0) begin
                first = cyc;
                $display("reset_mid: first update at cycle %0d ch0 both=%0d ch1 both=%0d", cyc, dut_avg(0, 2), dut_avg(1, 2));
                compared += 9;
                for (int t = 0; t < 3; t++) begin
                    if (dut_avg(0, t) !== '0) begin mismatched++; $display("FAIL mid_ch0_avg%0d got=%0d want=0", t, dut_avg(0, t)); end
                    if (dut_avg(1, t) !== CW'(4)) begin mismatched++; $display("FAIL mid_ch1_avg%0d got=%0d want=4", t, dut_avg(1, t)); end
                end
                if (dut_peak(0) !== '0) begin mismatched++; $display("FAIL mid_peak0 got=%0d want=0", dut_peak(0)); end
                if (dut_peak(1) !== CW'(16)) begin mismatched++; $display("FAIL mid_peak1 got=%0d want=16", dut_peak(1)); end
                if (window_cnt !== 16'd1) begin mismatched++; $display("FAIL mid_first_wcnt got=%0d want=1", window_cnt); end
            end
        end
        compared++;
        if (first != 17) begin mismatched++; $display("FAIL mid_first_update got=%0d want=17", first); end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] v;
        logic [NUM_CH-1:0] r;
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10 * WLEN + 2; i++) begin
            v = {1'($urandom % 2), 1'($urandom % 4 != 0)};
            r = {1'($urandom % 4 == 0), 1'($urandom % 2)};
            step(v, r, 1'($urandom % 40 == 0), 1'b1);
            compared += 2;
            if (update !== exp_update) begin mismatched++; $display("FAIL rand_update cyc=%0d got=%b want=%b", cyc, update, exp_update); end
            if (window_cnt !== 16'(exp_wcnt)) begin mismatched++; $display("FAIL rand_wcnt cyc=%0d got=%0d want=%0d", cyc, window_cnt, exp_wcnt); end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int t = 0; t < 3; t++) begin
                    compared++;
                    if (dut_avg(ch, t) !== CW'(exp_avg[ch][t])) begin
                        mismatched++;
                        $display("FAIL rand_avg ch%0d type%0d cyc=%0d got=%0d want=%0d", ch, t, cyc, dut_avg(ch, t), exp_avg[ch][t]);
                    end
                end
                compared++;
                if (dut_peak(ch) !== CW'(exp_peak[ch])) begin
                    mismatched++;
                    $display("FAIL rand_peak ch%0d cyc=%0d got=%0d want=%0d", ch, cyc, dut_peak(ch), exp_peak[ch]);
                end
            end
            if (exp_update)
                $display("random: window %0d ch0 v/r/b=%0d/%0d/%0d ch1 v/r/b=%0d/%0d/%0d", exp_wcnt,
                         dut_avg(0, 0), dut_avg(0, 1), dut_avg(0, 2), dut_avg(1, 0), dut_avg(1, 1), dut_avg(1, 2));
        end
    endtask

    initial begin
        rst           = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tready = '0;
        peak_clr      = 1'b0;
        cyc           = 0;
        nwin          = 0;
        test_reset();
        test_full();
        test_toggle();
        test_single();
        test_decay();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
